// File: rtl/display_fb_pkg.sv
// Shared types for the triple-buffer display frame scheduler: FSM encodings,
// buffer index type and the saturating statistics increment.
package display_fb_pkg;

  localparam int NUM_BUF = 3;
  localparam int CNT_W   = 16;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_ISSUE = 2'd1,
    WR_BUSY  = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_BUSY  = 2'd2
  } rd_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/display_fb_scheduler_if.sv
// Command/completion bundle between the frame scheduler (master) and the
// camera write DMA plus display read DMA (slave).
interface display_fb_scheduler_if #(
  parameter int ADDR_W = 32
);
  logic              wr_cmd_valid;
  logic              wr_cmd_ready;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic              wr_frame_done;
  logic              rd_cmd_valid;
  logic              rd_cmd_ready;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [23:0]       rd_cmd_len;
  logic              rd_frame_done;

  modport master (
    output wr_cmd_valid, wr_cmd_addr, rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    input  wr_cmd_ready, wr_frame_done, rd_cmd_ready, rd_frame_done
  );

  modport slave (
    input  wr_cmd_valid, wr_cmd_addr, rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    output wr_cmd_ready, wr_frame_done, rd_cmd_ready, rd_frame_done
  );
endinterface

// File: rtl/display_fb_scheduler_cmd_port.sv
// Single-entry valid/ready command holder: loads an address when empty and
// keeps valid and address stable until the consumer accepts it.
module fb_cmd_port #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              fire_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;

  assign fire_o  = valid_q & ready_i;
  assign valid_o = valid_q;
  assign addr_o  = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (load_i && !valid_q) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
    end else if (fire_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/display_fb_scheduler.sv
// Triple-buffer scheduler handing write/read DMAs their frame buffers.
// Optional statistics counters are built when DISPLAY_FB_STATS_EN is defined.
module display_fb_scheduler
  import display_fb_pkg::*;
#(
  parameter int                 ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  BUF_BASE    = 32'h0100_0000,
  parameter logic [ADDR_W-1:0]  BUF_STRIDE  = 32'h0040_0000,
  parameter logic [23:0]        FRAME_BYTES = 24'd1_166_400
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    disp_vs,
  display_fb_scheduler_if.master  dma,
  output logic [1:0]              wr_idx,
  output logic [1:0]              rd_idx,
  output logic                    proto_err,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]        repeat_cnt,
  output logic [CNT_W-1:0]        late_cnt
);

  localparam logic [ADDR_W-1:0] BUF_ADDR0 = BUF_BASE;
  localparam logic [ADDR_W-1:0] BUF_ADDR1 = BUF_BASE + BUF_STRIDE;
  localparam logic [ADDR_W-1:0] BUF_ADDR2 = BUF_BASE + (BUF_STRIDE << 1);

  function automatic logic [ADDR_W-1:0] buf_addr(input buf_idx_t idx);
    case (idx)
      2'd0:    return BUF_ADDR0;
      2'd1:    return BUF_ADDR1;
      default: return BUF_ADDR2;
    endcase
  endfunction

  logic      vs_r1_q, vs_r2_q;
  wr_state_e wr_state_q;
  rd_state_e rd_state_q;
  buf_idx_t  wr_idx_q, rd_idx_q, spare_idx_q;
  buf_idx_t  wr_idx_d, rd_idx_d, spare_idx_d;
  logic      fresh_q, fresh_d;
  logic      have_frame_q, proto_err_q;
  logic      wr_fire, rd_fire;
  logic      wr_done_ok, rd_done_ok, vs_fall, rd_start, rd_take;

  assign vs_fall    = vs_r2_q & ~vs_r1_q;
  assign wr_done_ok = dma.wr_frame_done & (wr_state_q == WR_BUSY);
  assign rd_done_ok = dma.rd_frame_done & (rd_state_q == RD_BUSY);
  // A frame finishing on the vsync edge itself is already eligible for display.
  assign rd_start   = vs_fall & (rd_state_q == RD_IDLE) & enable &
                      (have_frame_q | wr_done_ok);
  assign rd_take    = rd_start & (fresh_q | wr_done_ok);

  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    spare_idx_d = spare_idx_q;
    fresh_d     = fresh_q;
    if (wr_done_ok) begin
      wr_idx_d    = spare_idx_q;
      spare_idx_d = wr_idx_q;
      fresh_d     = 1'b1;
    end
    if (rd_take) begin
      rd_idx_d    = spare_idx_d;
      spare_idx_d = rd_idx_q;
      fresh_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r1_q      <= 1'b0;
      vs_r2_q      <= 1'b0;
      wr_state_q   <= WR_IDLE;
      rd_state_q   <= RD_IDLE;
      wr_idx_q     <= 2'd0;
      spare_idx_q  <= 2'd1;
      rd_idx_q     <= 2'd2;
      fresh_q      <= 1'b0;
      have_frame_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      vs_r1_q     <= disp_vs;
      vs_r2_q     <= vs_r1_q;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      spare_idx_q <= spare_idx_d;
      fresh_q     <= fresh_d;
      if (wr_done_ok)
        have_frame_q <= 1'b1;
      if ((dma.wr_frame_done && !wr_done_ok) || (dma.rd_frame_done && !rd_done_ok))
        proto_err_q <= 1'b1;

      case (wr_state_q)
        WR_IDLE:  if (enable)     wr_state_q <= WR_ISSUE;
        WR_ISSUE: if (wr_fire)    wr_state_q <= WR_BUSY;
        WR_BUSY:  if (wr_done_ok) wr_state_q <= enable ? WR_ISSUE : WR_IDLE;
        default:                  wr_state_q <= WR_IDLE;
      endcase

      case (rd_state_q)
        RD_IDLE:  if (rd_start)   rd_state_q <= RD_ISSUE;
        RD_ISSUE: if (rd_fire)    rd_state_q <= RD_BUSY;
        RD_BUSY:  if (rd_done_ok) rd_state_q <= RD_IDLE;
        default:                  rd_state_q <= RD_IDLE;
      endcase
    end
  end

  fb_cmd_port #(.ADDR_W(ADDR_W)) u_wr_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  ((wr_state_q == WR_ISSUE) && enable),
    .addr_i  (buf_addr(wr_idx_q)),
    .ready_i (dma.wr_cmd_ready),
    .valid_o (dma.wr_cmd_valid),
    .addr_o  (dma.wr_cmd_addr),
    .fire_o  (wr_fire)
  );

  fb_cmd_port #(.ADDR_W(ADDR_W)) u_rd_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  ((rd_state_q == RD_ISSUE) && enable),
    .addr_i  (buf_addr(rd_idx_q)),
    .ready_i (dma.rd_cmd_ready),
    .valid_o (dma.rd_cmd_valid),
    .addr_o  (dma.rd_cmd_addr),
    .fire_o  (rd_fire)
  );

  assign dma.rd_cmd_len = FRAME_BYTES;
  assign wr_idx         = wr_idx_q;
  assign rd_idx         = rd_idx_q;
  assign proto_err      = proto_err_q;

`ifdef DISPLAY_FB_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q, repeat_cnt_q, late_cnt_q;

  // An overwritten fresh frame counts as dropped unless the reader takes it on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q   <= '0;
      repeat_cnt_q <= '0;
      late_cnt_q   <= '0;
    end else begin
      if (wr_done_ok && fresh_q && !rd_take)
        drop_cnt_q <= sat_inc(drop_cnt_q);
      if (rd_start && !rd_take)
        repeat_cnt_q <= sat_inc(repeat_cnt_q);
      if (vs_fall && (rd_state_q != RD_IDLE))
        late_cnt_q <= sat_inc(late_cnt_q);
    end
  end

  assign drop_cnt   = drop_cnt_q;
  assign repeat_cnt = repeat_cnt_q;
  assign late_cnt   = late_cnt_q;
`else
  assign drop_cnt   = '0;
  assign repeat_cnt = '0;
  assign late_cnt   = '0;
`endif

endmodule

// File: tb/tb_display_fb_scheduler.sv
// Directed bench for display_fb_scheduler: buffer-ownership model checked
// every cycle plus hand-computed expectations for latency and corner cases.
module tb_display_fb_scheduler;
  localparam logic [31:0] BASE   = 32'h0100_0000;
  localparam logic [31:0] STRIDE = 32'h0040_0000;
  localparam logic [31:0] FLEN   = 32'd1_166_400;
`ifdef DISPLAY_FB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic disp_vs = 1'b1;
  logic [1:0] wr_idx, rd_idx;
  logic proto_err;
  logic [15:0] drop_cnt, repeat_cnt, late_cnt;

  int n_chk = 0;
  int n_fail = 0;

  display_fb_scheduler_if #(.ADDR_W(32)) bus ();

  display_fb_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .disp_vs    (disp_vs),
    .dma        (bus),
    .wr_idx     (wr_idx),
    .rd_idx     (rd_idx),
    .proto_err  (proto_err),
    .drop_cnt   (drop_cnt),
    .repeat_cnt (repeat_cnt),
    .late_cnt   (late_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cexp(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  // ---------------- behavioural ownership model ----------------
  int m_wr, m_rd, m_sp, m_drop, m_rep, m_late;
  bit m_fresh, m_have, m_perr, m_wbusy, m_rbusy, m_rcomm, h1, h2;

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_sp = 1; m_rd = 2;
    m_fresh = 0; m_have = 0; m_perr = 0;
    m_wbusy = 0; m_rbusy = 0; m_rcomm = 0;
    m_drop = 0; m_rep = 0; m_late = 0;
    h1 = 0; h2 = 0;
  endtask

  task automatic model_step();
    bit fall, wdone, rdone, start;
    int t;
    fall  = h2 && !h1;
    wdone = bus.wr_frame_done && m_wbusy;
    rdone = bus.rd_frame_done && m_rbusy;
    if (bus.wr_frame_done && !m_wbusy) m_perr = 1;
    if (bus.rd_frame_done && !m_rbusy) m_perr = 1;
    start = fall && !m_rcomm && enable && (m_have || wdone);
    if (fall && m_rcomm) m_late = sat16(m_late);
    if (wdone) begin
      t = m_wr; m_wr = m_sp; m_sp = t;
      if (m_fresh && !start) m_drop = sat16(m_drop);
      m_fresh = 1; m_have = 1; m_wbusy = 0;
    end
    if (start) begin
      m_rcomm = 1;
      if (m_fresh) begin
        t = m_rd; m_rd = m_sp; m_sp = t; m_fresh = 0;
      end else begin
        m_rep = sat16(m_rep);
      end
    end
    if (rdone) begin m_rbusy = 0; m_rcomm = 0; end
    if (bus.wr_cmd_valid && bus.wr_cmd_ready) m_wbusy = 1;
    if (bus.rd_cmd_valid && bus.rd_cmd_ready) m_rbusy = 1;
    h2 = h1; h1 = disp_vs;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("wr_idx", 32'(wr_idx), 32'(m_wr));
        chk("rd_idx", 32'(rd_idx), 32'(m_rd));
        chk("idx_distinct", 32'(wr_idx != rd_idx && wr_idx < 2'd3 && rd_idx < 2'd3), 32'd1);
        chk("proto_err", 32'(proto_err), 32'(m_perr));
        chk("drop_cnt", 32'(drop_cnt), cexp(m_drop));
        chk("repeat_cnt", 32'(repeat_cnt), cexp(m_rep));
        chk("late_cnt", 32'(late_cnt), cexp(m_late));
        if (bus.wr_cmd_valid) chk("wr_cmd_addr_model", bus.wr_cmd_addr, BASE + 32'(m_wr) * STRIDE);
        if (bus.rd_cmd_valid) begin
          chk("rd_cmd_addr_model", bus.rd_cmd_addr, BASE + 32'(m_rd) * STRIDE);
          chk("rd_cmd_len", 32'(bus.rd_cmd_len), FLEN);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_wr_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.wr_cmd_valid && n < 20);
  endtask

  task automatic wait_rd_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rd_cmd_valid && n < 20);
  endtask

  task automatic pulse_wr_done();
    bus.wr_frame_done = 1'b1;
    @(negedge clk);
    bus.wr_frame_done = 1'b0;
  endtask

  task automatic pulse_rd_done();
    bus.rd_frame_done = 1'b1;
    @(negedge clk);
    bus.rd_frame_done = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    bit seen;
    bus.wr_cmd_ready = 1'b0; bus.rd_cmd_ready = 1'b0;
    bus.wr_frame_done = 1'b0; bus.rd_frame_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_wr_idx", 32'(wr_idx), 32'd0);
    chk("reset_rd_idx", 32'(rd_idx), 32'd2);
    chk("reset_wr_valid", 32'(bus.wr_cmd_valid), 32'd0);
    chk("reset_rd_valid", 32'(bus.rd_cmd_valid), 32'd0);
    chk("reset_wr_addr", bus.wr_cmd_addr, 32'd0);
    chk("reset_rd_addr", bus.rd_cmd_addr, 32'd0);
    chk("reset_proto_err", 32'(proto_err), 32'd0);

    // First write command after enable
    enable = 1'b1; bus.wr_cmd_ready = 1'b1;
    wait_wr_valid(n);
    chk("wr_valid_latency_enable", 32'(n), 32'd2);
    chk("wr_addr_first", bus.wr_cmd_addr, 32'h0100_0000);
    @(negedge clk);
    chk("wr_valid_one_cycle", 32'(bus.wr_cmd_valid), 32'd0);

    // Vsync before any completed frame: no read command
    disp_vs = 1'b0; seen = 0;
    repeat (6) begin @(negedge clk); seen |= bus.rd_cmd_valid; end
    disp_vs = 1'b1;
    repeat (3) begin @(negedge clk); seen |= bus.rd_cmd_valid; end
    chk("no_rd_before_frame", 32'(seen), 32'd0);

    // First frame completes, then displayed
    pulse_wr_done();
    wait_wr_valid(n);
    chk("wr_valid_latency_done", 32'(n), 32'd1);
    chk("wr_addr_second", bus.wr_cmd_addr, 32'h0140_0000);
    disp_vs = 1'b0;
    wait_rd_valid(n);
    chk("rd_valid_latency_vs", 32'(n), 32'd3);
    chk("rd_addr_first", bus.rd_cmd_addr, 32'h0100_0000);
    chk("rd_len", 32'(bus.rd_cmd_len), 32'd1_166_400);
    disp_vs = 1'b1; bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bus.rd_cmd_valid || bus.rd_cmd_addr !== 32'h0100_0000) bad++;
    end
    chk("rd_hold_stable_errors", 32'(bad), 32'd0);
    bus.rd_cmd_ready = 1'b1;
    @(negedge clk);
    chk("rd_valid_drop_after_accept", 32'(bus.rd_cmd_valid), 32'd0);
    pulse_rd_done();

    // No new frame: repeat previous buffer
    disp_vs = 1'b0;
    wait_rd_valid(n);
    chk("rd_addr_repeat", bus.rd_cmd_addr, 32'h0100_0000);
    chk("repeat_cnt_lit", 32'(repeat_cnt), cexp(1));
    @(negedge clk);
    disp_vs = 1'b1;
    repeat (2) @(negedge clk);

    // Vsync while reader busy
    disp_vs = 1'b0; seen = 0;
    repeat (6) begin @(negedge clk); seen |= bus.rd_cmd_valid; end
    chk("no_rd_when_late", 32'(seen), 32'd0);
    chk("late_cnt_lit", 32'(late_cnt), cexp(1));
    disp_vs = 1'b1;
    repeat (3) @(negedge clk);
    pulse_rd_done();

    // Two frames between vsyncs: one dropped, latest shown
    pulse_wr_done();
    wait_wr_valid(n);
    @(negedge clk);
    repeat (2) @(negedge clk);
    pulse_wr_done();
    wait_wr_valid(n);
    @(negedge clk);
    chk("drop_cnt_lit", 32'(drop_cnt), cexp(1));
    disp_vs = 1'b0;
    wait_rd_valid(n);
    chk("rd_addr_latest", bus.rd_cmd_addr, 32'h0180_0000);
    chk("rd_idx_latest", 32'(rd_idx), 32'd2);
    @(negedge clk);
    disp_vs = 1'b1;
    repeat (2) @(negedge clk);
    pulse_rd_done();

    // Frame completes on the same edge as the read swap
    pulse_wr_done();
    wait_wr_valid(n);
    @(negedge clk);
    repeat (2) @(negedge clk);
    disp_vs = 1'b0;
    @(negedge clk);
    bus.wr_frame_done = 1'b1;
    @(negedge clk);
    bus.wr_frame_done = 1'b0;
    chk("simul_rd_idx", 32'(rd_idx), 32'd0);
    chk("simul_wr_idx", 32'(wr_idx), 32'd1);
    chk("simul_drop_unchanged", 32'(drop_cnt), cexp(1));
    wait_rd_valid(n);
    chk("simul_rd_latency", 32'(n), 32'd1);
    chk("simul_rd_addr", bus.rd_cmd_addr, 32'h0100_0000);
    @(negedge clk);
    disp_vs = 1'b1;
    repeat (2) @(negedge clk);
    pulse_rd_done();

    // Completion pulse with no read in flight
    repeat (2) @(negedge clk);
    chk("proto_err_before", 32'(proto_err), 32'd0);
    pulse_rd_done();
    chk("proto_err_after", 32'(proto_err), 32'd1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
